// File: rtl/decimal_alu_sequencer.sv
// decimal_alu_sequencer: two-stage ADC/SBC unit with decimal adjust and valid/ready handshake.
// BIN forms the binary sum and decimal carries, ADJ applies nibble-local correction.
module decimal_alu_sequencer #(
  parameter bit NMOS_FLAGS  = 1'b1,
  parameter bit BINARY_FAST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       op_sub,
  input  logic       decimal,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       c_out,
  output logic       v_out,
  output logic       n_out,
  output logic       z_out
);
  typedef enum logic [1:0] {IDLE, BIN, ADJ, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d, s_q, s_d, res_q, res_d;
  logic c_q, c_d, sub_q, sub_d, dec_q, dec_d, hc_q, hc_d, acr_q, acr_d, v_q, v_d;
  logic co_q, co_d, vo_q, vo_d, n_q, n_d, z_q, z_d;
  logic [4:0] l, h;
  logic [7:0] s, adj, nz;
  logic [3:0] adj_lo, adj_hi;
  logic daa, dsa, hc, acr, v, accept, fin_bin, fin_adj;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      dec_q   <= 1'b0;
      s_q     <= '0;
      hc_q    <= 1'b0;
      acr_q   <= 1'b0;
      v_q     <= 1'b0;
      res_q   <= '0;
      co_q    <= 1'b0;
      vo_q    <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sub_q   <= sub_d;
      dec_q   <= dec_d;
      s_q     <= s_d;
      hc_q    <= hc_d;
      acr_q   <= acr_d;
      v_q     <= v_d;
      res_q   <= res_d;
      co_q    <= co_d;
      vo_q    <= vo_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid ? BIN : IDLE;
      BIN:     state_d = (BINARY_FAST && !dec_q) ? DONE : ADJ;
      ADJ:     state_d = DONE;
      default: state_d = out_ready ? (in_valid ? BIN : IDLE) : DONE;
    endcase
  end
  always_comb begin
    in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    out_valid = state_q == DONE;
  end
  always_comb begin
    accept  = in_valid && in_ready;
    daa     = dec_q && !sub_q;
    dsa     = dec_q && sub_q;
    l       = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'd0, c_q};
    hc      = daa ? (l > 5'd9) : l[4];
    h       = {1'b0, a_q[7:4]} + {1'b0, b_q[7:4]} + {4'd0, hc};
    acr     = daa ? (h > 5'd9) : h[4];
    s       = {h[3:0], l[3:0]};
    v       = (a_q[7] ~^ b_q[7]) & (a_q[7] ^ h[3]);
    // +0xA is -6 mod 16: the borrow-side correction stays inside its nibble
    adj_lo  = s_q[3:0] + ((daa && hc_q) ? 4'h6 : (dsa && !hc_q) ? 4'hA : 4'h0);
    adj_hi  = s_q[7:4] + ((daa && acr_q) ? 4'h6 : (dsa && !acr_q) ? 4'hA : 4'h0);
    adj     = {adj_hi, adj_lo};
    fin_bin = (state_q == BIN) && (state_d == DONE);
    fin_adj = state_q == ADJ;
    nz      = fin_bin ? s : (NMOS_FLAGS ? s_q : adj);
    a_d     = accept ? a : a_q;
    b_d     = accept ? (op_sub ? ~b : b) : b_q;
    c_d     = accept ? c_in : c_q;
    sub_d   = accept ? op_sub : sub_q;
    dec_d   = accept ? decimal : dec_q;
    s_d     = (state_q == BIN) ? s : s_q;
    hc_d    = (state_q == BIN) ? hc : hc_q;
    acr_d   = (state_q == BIN) ? acr : acr_q;
    v_d     = (state_q == BIN) ? v : v_q;
    res_d   = fin_adj ? adj : fin_bin ? s : res_q;
    co_d    = fin_adj ? acr_q : fin_bin ? acr : co_q;
    vo_d    = fin_adj ? v_q : fin_bin ? v : vo_q;
    n_d     = (fin_adj || fin_bin) ? nz[7] : n_q;
    z_d     = (fin_adj || fin_bin) ? (nz == 8'h00) : z_q;
  end
  assign result = res_q;
  assign c_out  = co_q;
  assign v_out  = vo_q;
  assign n_out  = n_q;
  assign z_out  = z_q;
endmodule

// File: tb/tb_decimal_alu_sequencer.sv
// tb_decimal_alu_sequencer: table, random and corner-sequence checks of the decimal ALU.
// u0 uses default parameters; u1 uses NMOS_FLAGS=0, BINARY_FAST=1.
module tb_decimal_alu_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, f_in_valid = 1'b0, out_ready = 1'b1;
  logic op_sub = 1'b0, decimal = 1'b0, c_in = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic in_ready, out_valid, c_out, v_out, n_out, z_out;
  logic f_in_ready, f_out_valid, f_c_out, f_v_out, f_n_out, f_z_out;
  logic [7:0] result, f_result;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  decimal_alu_sequencer u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .decimal(decimal), .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .c_out(c_out), .v_out(v_out), .n_out(n_out), .z_out(z_out)
  );

  decimal_alu_sequencer #(.NMOS_FLAGS(1'b0), .BINARY_FAST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .op_sub(op_sub), .decimal(decimal), .a(a), .b(b), .c_in(c_in),
    .out_valid(f_out_valid), .out_ready(out_ready), .result(f_result),
    .c_out(f_c_out), .v_out(f_v_out), .n_out(f_n_out), .z_out(f_z_out)
  );

  typedef struct {
    bit sel; bit sub; bit dec; logic [7:0] a; logic [7:0] b; bit c;
    logic [7:0] res; bit co; bit vo; bit no; bit zo; int lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal ADC uses per-nibble >9 carries; decimal SBC is the binary difference
  // with 6 subtracted from every nibble that borrowed.
  function automatic vec_t model(input bit sel, input bit sub, input bit dec,
                                 input logic [7:0] av, input logic [7:0] bv, input bit c);
    vec_t v;
    int lo, hi, d;
    bit hc;
    logic [7:0] bb, s, nz;
    logic [3:0] rl, rh;
    v.sel = sel; v.sub = sub; v.dec = dec; v.a = av; v.b = bv; v.c = c;
    bb = sub ? ~bv : bv;
    if (dec && !sub) begin
      lo = av[3:0] + bv[3:0] + c;
      hc = lo > 9;
      hi = av[7:4] + bv[7:4] + hc;
      v.co = hi > 9;
      s = {hi[3:0], lo[3:0]};
      rl = lo[3:0] + (hc ? 4'd6 : 4'd0);
      rh = hi[3:0] + (v.co ? 4'd6 : 4'd0);
    end else if (dec) begin
      d = int'(av) - int'(bv) - (c ? 0 : 1);
      v.co = d >= 0;
      hc = (int'(av[3:0]) - int'(bv[3:0]) - (c ? 0 : 1)) >= 0;
      s = d[7:0];
      rl = s[3:0] - (hc ? 4'd0 : 4'd6);
      rh = s[7:4] - (v.co ? 4'd0 : 4'd6);
    end else begin
      d = av + bb + c;
      v.co = d > 255;
      s = d[7:0];
      rl = s[3:0];
      rh = s[7:4];
    end
    v.res = {rh, rl};
    v.vo = (av[7] == bb[7]) && (av[7] != s[7]);
    nz = sel ? v.res : s;
    v.no = nz[7];
    v.zo = nz == 8'h00;
    v.lat = (sel && !dec) ? 1 : 2;
    return v;
  endfunction

  task automatic run(input vec_t v, input string t);
    int lat;
    @(negedge clk);
    op_sub = v.sub; decimal = v.dec; a = v.a; b = v.b; c_in = v.c;
    if (v.sel) f_in_valid = 1'b1; else in_valid = 1'b1;
    #1 chk({t, ".in_ready"}, v.sel ? f_in_ready : in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0; f_in_valid = 1'b0;
    lat = 0;
    while (!(v.sel ? f_out_valid : out_valid) && lat < 8) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({t, ".latency"}, lat, v.lat);
    chk({t, ".result"}, v.sel ? f_result : result, v.res);
    chk({t, ".c"}, v.sel ? f_c_out : c_out, v.co);
    chk({t, ".v"}, v.sel ? f_v_out : v_out, v.vo);
    chk({t, ".n"}, v.sel ? f_n_out : n_out, v.no);
    chk({t, ".z"}, v.sel ? f_z_out : z_out, v.zo);
    @(posedge clk);
    #1 chk({t, ".drain"}, v.sel ? f_out_valid : out_valid, 0);
  endtask

  initial begin
    tbl[0] = '{0, 0, 1, 8'h19, 8'h28, 0, 8'h47, 0, 0, 0, 0, 2};
    tbl[1] = '{0, 0, 1, 8'h99, 8'h01, 0, 8'h00, 1, 0, 1, 0, 2};
    tbl[2] = '{1, 0, 1, 8'h99, 8'h01, 0, 8'h00, 1, 0, 0, 1, 2};
    tbl[3] = '{0, 1, 1, 8'h42, 8'h13, 1, 8'h29, 1, 0, 0, 0, 2};
    tbl[4] = '{0, 1, 1, 8'h00, 8'h01, 1, 8'h99, 0, 0, 1, 0, 2};
    tbl[5] = '{0, 0, 0, 8'h50, 8'h50, 0, 8'hA0, 0, 1, 1, 0, 2};
    tbl[6] = '{1, 0, 0, 8'h50, 8'h50, 0, 8'hA0, 0, 1, 1, 0, 1};
    tbl[7] = '{0, 1, 0, 8'h00, 8'h01, 1, 8'hFF, 0, 0, 1, 0, 2};
    tbl[8] = '{0, 0, 0, 8'hFF, 8'h01, 0, 8'h00, 1, 0, 0, 1, 2};
    tbl[9] = '{1, 1, 1, 8'h00, 8'h01, 1, 8'h99, 0, 0, 1, 0, 2};

    #12;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.result", result, 8'h00);
    chk("rst.flags", {c_out, v_out, n_out, z_out}, 0);
    chk("rst.f_in_ready", f_in_ready, 1);
    chk("rst.f_out_valid", f_out_valid, 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) run(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 150; i++)
      run(model($urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(1, 0),
                8'($urandom), 8'($urandom), $urandom_range(1, 0)), $sformatf("rnd%0d", i));

    // busy inputs ignored, then backpressure hold, then back-to-back accept
    @(negedge clk);
    out_ready = 1'b0; op_sub = 0; decimal = 1; a = 8'h19; b = 8'h28; c_in = 0; in_valid = 1;
    @(posedge clk);
    #1 a = 8'hFF; b = 8'hFF;
    chk("busy.in_ready0", in_ready, 0);
    @(posedge clk);
    #1 chk("busy.in_ready1", in_ready, 0);
    chk("busy.out_valid", out_valid, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp.out_valid", out_valid, 1);
    chk("bp.result", result, 8'h47);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk("hold.result", result, 8'h47);
      chk("hold.flags", {c_out, v_out, n_out, z_out}, 0);
      chk("hold.out_valid", out_valid, 1);
      chk("hold.in_ready", in_ready, 0);
    end
    @(negedge clk);
    a = 8'h99; b = 8'h01; c_in = 0; in_valid = 1; out_ready = 1;
    #1 chk("b2b.in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("b2b.bin_valid", out_valid, 0);
    chk("b2b.hold_result", result, 8'h47);
    @(posedge clk);
    #1 chk("b2b.adj_valid", out_valid, 0);
    @(posedge clk);
    #1 chk("b2b.out_valid", out_valid, 1);
    chk("b2b.result", result, 8'h00);
    chk("b2b.flags", {c_out, v_out, n_out, z_out}, 4'b1010);
    @(posedge clk);
    #1 chk("b2b.drain", out_valid, 0);

    // asynchronous reset in the middle of BIN
    run(tbl[5], "pre_rst");
    @(negedge clk);
    op_sub = 0; decimal = 0; a = 8'h12; b = 8'h34; c_in = 0; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("arst.out_valid", out_valid, 0);
    chk("arst.result", result, 8'h00);
    chk("arst.flags", {c_out, v_out, n_out, z_out}, 0);
    chk("arst.in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("arst.in_ready_rel", in_ready, 1);
    run(tbl[0], "post_rst");
    run(tbl[3], "post_rst_sbc");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
